// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: consumes DIGIT bits of each operand per clock,
// LSB first, and presents the WIDTH-bit result with carry-out and signed overflow.
module digit_serial_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // WIDTH must be a multiple of DIGIT; N digits make up one operand.
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LASTCNT = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           statenext;
  logic [WIDTH-1:0] xreg;
  logic [WIDTH-1:0] yreg;
  logic [WIDTH-1:0] psum;
  logic [WIDTH-1:0] psumnext;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] dsum;
  logic             dcarry;
  logic             lastdigit;
  logic             msbcarryin;
  logic             accept;

  // Operand registers shift right, so the active digit always sits in the low DIGIT bits.
  assign {dcarry, dsum} = {1'b0, xreg[DIGIT-1:0]} + {1'b0, yreg[DIGIT-1:0]}
                          + {{DIGIT{1'b0}}, carry};
  assign lastdigit  = (cnt == LASTCNT);
  assign msbcarryin = dsum[DIGIT-1] ^ xreg[DIGIT-1] ^ yreg[DIGIT-1];
  assign accept     = start && (state != RUN);

  // Partial sums enter from the top so the final digit lands in the MSBs.
  generate
    if (N == 1) begin : g_single
      assign psumnext = dsum;
    end else begin : g_multi
      assign psumnext = {dsum, psum[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_comb begin
    statenext = state;
    case (state)
      IDLE, DONE: statenext = start ? RUN : IDLE;
      RUN:        statenext = lastdigit ? DONE : RUN;
      default:    statenext = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      xreg  <= '0;
      yreg  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= statenext;
      if (accept) begin
        // Subtraction is x + ~y + 1, so the inversion and carry tweak happen at capture.
        xreg  <= x;
        yreg  <= sub ? ~y : y;
        carry <= cin ^ sub;
        cnt   <= '0;
      end else if (state == RUN) begin
        xreg  <= xreg >> DIGIT;
        yreg  <= yreg >> DIGIT;
        psum  <= psumnext;
        carry <= dcarry;
        cnt   <= cnt + CW'(1);
        if (lastdigit) begin
          sum  <= psumnext;
          cout <= dcarry;
          ovf  <= msbcarryin ^ dcarry;
        end
      end
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for digit_serial_adder: a 32/8 instance for the main scenarios
// and an 8/8 instance for the single-digit corner.
module tb_digit_serial_adder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        busy, done, cout, ovf;
  logic [31:0] sum;

  logic        start8 = 1'b0;
  logic [7:0]  x8 = '0;
  logic [7:0]  y8 = '0;
  logic        cin8 = 1'b0;
  logic        sub8 = 1'b0;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(32), .DIGIT(8)) dut (
    .clk(clk), .reset(reset), .start(start), .x(x), .y(y), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  digit_serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .x(x8), .y(y8), .cin(cin8), .sub(sub8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  // Launches one operation, scrambles the inputs after capture, waits (bounded) for done.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic s, output int busycnt, output bit sawdone);
    int cyc;
    start = 1'b1; x = a; y = b; cin = c; sub = s;
    @(posedge clk); #1;
    start = 1'b0; x = ~a; y = ~b ^ 32'h1234_5678; cin = ~c; sub = ~s;
    busycnt = 0;
    cyc = 0;
    while (!done && cyc < 20) begin
      if (busy) busycnt++;
      @(posedge clk); #1;
      cyc++;
    end
    sawdone = done;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done got %b want 0", done); end
    compared++; if (sum !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_sum got %h want 0", sum); end
    compared++; if ({cout, ovf} !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_flags got %b want 00", {cout, ovf}); end
    compared++; if ({busy8, done8, sum8} !== 10'h0) begin mismatched++; $display("[TB] FAIL reset_narrow got %h want 0", {busy8, done8, sum8}); end
  endtask

  task automatic test_carry;
    int  bc;
    bit  sd;
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, bc, sd);
    compared++; if (sd !== 1'b1) begin mismatched++; $display("[TB] FAIL carry_done got %b want 1", sd); end
    compared++; if (bc != 4) begin mismatched++; $display("[TB] FAIL carry_busycycles got %0d want 4", bc); end
    compared++; if (sum !== 32'h0000_0100) begin mismatched++; $display("[TB] FAIL carry_sum got %h want 00000100", sum); end
    compared++; if ({cout, ovf} !== 2'b00) begin mismatched++; $display("[TB] FAIL carry_flags got %b want 00", {cout, ovf}); end
    @(posedge clk); #1;
    compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL carry_donepulse got %b want 0", done); end
    compared++; if (sum !== 32'h0000_0100) begin mismatched++; $display("[TB] FAIL carry_sumhold got %h want 00000100", sum); end
  endtask

  task automatic test_wrap;
    int  bc;
    bit  sd;
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, bc, sd);
    compared++; if (sd !== 1'b1) begin mismatched++; $display("[TB] FAIL wrap_done got %b want 1", sd); end
    compared++; if (sum !== 32'h0) begin mismatched++; $display("[TB] FAIL wrap_sum got %h want 00000000", sum); end
    compared++; if ({cout, ovf} !== 2'b10) begin mismatched++; $display("[TB] FAIL wrap_flags got %b want 10", {cout, ovf}); end
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, bc, sd);
    compared++; if (sd !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_done got %b want 1", sd); end
    compared++; if (sum !== 32'h8000_0000) begin mismatched++; $display("[TB] FAIL ovf_sum got %h want 80000000", sum); end
    compared++; if ({cout, ovf} !== 2'b01) begin mismatched++; $display("[TB] FAIL ovf_flags got %b want 01", {cout, ovf}); end
  endtask

  task automatic test_subtract;
    int  bc;
    bit  sd;
    run_op(32'd5, 32'd7, 1'b0, 1'b1, bc, sd);
    compared++; if (sd !== 1'b1) begin mismatched++; $display("[TB] FAIL sub_neg_done got %b want 1", sd); end
    compared++; if (sum !== 32'hFFFF_FFFE) begin mismatched++; $display("[TB] FAIL sub_neg_sum got %h want fffffffe", sum); end
    compared++; if ({cout, ovf} !== 2'b00) begin mismatched++; $display("[TB] FAIL sub_neg_flags got %b want 00", {cout, ovf}); end
    run_op(32'd7, 32'd5, 1'b0, 1'b1, bc, sd);
    compared++; if (sd !== 1'b1) begin mismatched++; $display("[TB] FAIL sub_pos_done got %b want 1", sd); end
    compared++; if (sum !== 32'h0000_0002) begin mismatched++; $display("[TB] FAIL sub_pos_sum got %h want 00000002", sum); end
    compared++; if ({cout, ovf} !== 2'b10) begin mismatched++; $display("[TB] FAIL sub_pos_flags got %b want 10", {cout, ovf}); end
  endtask

  task automatic test_back_to_back;
    start = 1'b1; x = 32'd1; y = 32'd2; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; x = 32'd9; y = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL ignore_busy got %b want 1", busy); end
    @(posedge clk); #1;
    compared++; if (sum !== 32'h0000_0002) begin mismatched++; $display("[TB] FAIL run_sumhold got %h want 00000002", sum); end
    @(posedge clk); #1;
    compared++; if (done !== 1'b1) begin mismatched++; $display("[TB] FAIL ignore_done got %b want 1", done); end
    compared++; if (sum !== 32'h0000_0003) begin mismatched++; $display("[TB] FAIL ignore_sum got %h want 00000003", sum); end
    start = 1'b1; x = 32'd4; y = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    compared++; if ({busy, done} !== 2'b10) begin mismatched++; $display("[TB] FAIL b2b_busy got %b want 10", {busy, done}); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_early_done cycle %0d got %b want 0", i, done); end
    end
    @(posedge clk); #1;
    compared++; if (done !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_done got %b want 1", done); end
    compared++; if (sum !== 32'h0000_0008) begin mismatched++; $display("[TB] FAIL b2b_sum got %h want 00000008", sum); end
  endtask

  task automatic test_reset_mid;
    int  bc;
    bit  sd;
    start = 1'b1; x = 32'hFFFF_FFFF; y = 32'd1; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    compared++; if ({busy, done} !== 2'b00) begin mismatched++; $display("[TB] FAIL abort_state got %b want 00", {busy, done}); end
    compared++; if (sum !== 32'h0) begin mismatched++; $display("[TB] FAIL abort_sum got %h want 00000000", sum); end
    compared++; if ({cout, ovf} !== 2'b00) begin mismatched++; $display("[TB] FAIL abort_flags got %b want 00", {cout, ovf}); end
    run_op(32'd2, 32'd3, 1'b0, 1'b0, bc, sd);
    compared++; if (sd !== 1'b1 || bc != 4) begin mismatched++; $display("[TB] FAIL post_reset_timing got done=%b busy=%0d want done=1 busy=4", sd, bc); end
    compared++; if (sum !== 32'h0000_0005) begin mismatched++; $display("[TB] FAIL post_reset_sum got %h want 00000005", sum); end
  endtask

  task automatic test_narrow;
    start8 = 1'b1; x8 = 8'hFF; y8 = 8'h01; cin8 = 1'b1; sub8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0; x8 = 8'h00; cin8 = 1'b0;
    compared++; if ({busy8, done8} !== 2'b10) begin mismatched++; $display("[TB] FAIL narrow_busy got %b want 10", {busy8, done8}); end
    @(posedge clk); #1;
    compared++; if ({busy8, done8} !== 2'b01) begin mismatched++; $display("[TB] FAIL narrow_done got %b want 01", {busy8, done8}); end
    compared++; if (sum8 !== 8'h01) begin mismatched++; $display("[TB] FAIL narrow_sum got %h want 01", sum8); end
    compared++; if ({cout8, ovf8} !== 2'b10) begin mismatched++; $display("[TB] FAIL narrow_flags got %b want 10", {cout8, ovf8}); end
  endtask

  initial begin
    test_reset;
    test_carry;
    test_wrap;
    test_subtract;
    test_back_to_back;
    test_reset_mid;
    test_narrow;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
